// File: rtl/modexp_param_core_if.sv
// Operand/result handshake bundle for modexp_param_core: operands in on in_valid_i/in_ready_o,
// result out on out_valid_o/out_ready_i with err_o qualifying res_o.
interface modexp_param_core_if #(
  parameter int WIDTH = 64
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] msg_i;
  logic [WIDTH-1:0] exp_i;
  logic [WIDTH-1:0] mod_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] res_o;
  logic             err_o;
  logic             busy_o;

  modport master (
    output in_valid_i, msg_i, exp_i, mod_i, out_ready_i,
    input  in_ready_o, out_valid_o, res_o, err_o, busy_o
  );

  modport slave (
    input  in_valid_i, msg_i, exp_i, mod_i, out_ready_i,
    output in_ready_o, out_valid_o, res_o, err_o, busy_o
  );
endinterface

// File: rtl/modexp_param_core.sv
// msg^exp mod mod via right-to-left square-and-multiply on two bit-serial multipliers; result after WIDTH*(1+N)
// cycles (1 cycle for mod==0) and held until out_ready_i. MODEXP_CONST_TIME_EN forces N=WIDTH for every modulus.
module modexp_param_core #(
  parameter int WIDTH = 64
) (
  input  logic               clk_i,
  input  logic               rst_i,
  modexp_param_core_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, REDUCE, EXP, DONE} state_t;
  state_t state, state_nxt;

  logic [WIDTH-1:0] m_q, e_q, sa_q, sb_q, pa_q, pb_q, base_q, result_q, res_q;
  logic [WIDTH-1:0] pa_nxt, pb_nxt, one, mul_b, res_new;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q, m_zero, last_step, exp_none, exp_done;
  logic             in_ready, out_valid, busy;
`ifdef MODEXP_CONST_TIME_EN
  logic [CNT_W-1:0] iter_q;
`endif

  // One MSB-first interleaved step; the extra top bit absorbs 2P and T+b before reduction.
  function automatic logic [WIDTH-1:0] mm_step(input logic [WIDTH-1:0] p, input logic abit,
                                               input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] m);
    logic [WIDTH:0] t;
    logic [WIDTH:0] mx;
    mx = {1'b0, m};
    t  = {p, 1'b0};
    if (t >= mx) t = t - mx;
    if (abit) begin
      t = t + {1'b0, b};
      if (t >= mx) t = t - mx;
    end
    return t[WIDTH-1:0];
  endfunction

  assign m_zero    = (m_q == '0);
  assign one       = {{(WIDTH-1){1'b0}}, (m_q != WIDTH'(1))};
  assign last_step = (cnt_q == CNT_W'(WIDTH - 1));
  assign mul_b     = (state == REDUCE) ? one : base_q;
  assign pa_nxt    = mm_step(pa_q, sa_q[WIDTH-1], mul_b, m_q);
  assign pb_nxt    = mm_step(pb_q, sb_q[WIDTH-1], base_q, m_q);
  assign res_new   = e_q[0] ? pa_nxt : result_q;

`ifdef MODEXP_CONST_TIME_EN
  assign exp_none = 1'b0;
  assign exp_done = (iter_q == CNT_W'(WIDTH - 1));
`else
  assign exp_none = (e_q == '0);
  assign exp_done = (e_q[WIDTH-1:1] == '0);
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (bus.in_valid_i) state_nxt = REDUCE;
      end
      REDUCE: begin
        if (m_zero)         state_nxt = DONE;
        else if (last_step) state_nxt = exp_none ? DONE : EXP;
      end
      EXP: begin
        if (last_step && exp_done) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_q      <= '0;
      e_q      <= '0;
      sa_q     <= '0;
      sb_q     <= '0;
      pa_q     <= '0;
      pb_q     <= '0;
      base_q   <= '0;
      result_q <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
`ifdef MODEXP_CONST_TIME_EN
      iter_q   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid_i) begin
            m_q   <= bus.mod_i;
            e_q   <= bus.exp_i;
            sa_q  <= bus.msg_i;
            pa_q  <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
          end
        end
        REDUCE: begin
          if (m_zero) begin
            res_q <= '0;
            err_q <= 1'b1;
          end else begin
            pa_q  <= pa_nxt;
            sa_q  <= sa_q << 1;
            cnt_q <= cnt_q + CNT_W'(1);
            if (last_step) begin
              // Reduced base feeds both multipliers; result starts at one.
              base_q   <= pa_nxt;
              result_q <= one;
              res_q    <= one;
              pa_q     <= '0;
              pb_q     <= '0;
              sa_q     <= one;
              sb_q     <= pa_nxt;
              cnt_q    <= '0;
`ifdef MODEXP_CONST_TIME_EN
              iter_q   <= '0;
`endif
            end
          end
        end
        EXP: begin
          pb_q  <= pb_nxt;
          sb_q  <= sb_q << 1;
          cnt_q <= cnt_q + CNT_W'(1);
`ifdef MODEXP_CONST_TIME_EN
          pa_q  <= pa_nxt;
          sa_q  <= sa_q << 1;
`else
          if (e_q[0]) begin
            pa_q <= pa_nxt;
            sa_q <= sa_q << 1;
          end
`endif
          if (last_step) begin
            result_q <= res_new;
            res_q    <= res_new;
            base_q   <= pb_nxt;
            e_q      <= e_q >> 1;
            pa_q     <= '0;
            pb_q     <= '0;
            sa_q     <= res_new;
            sb_q     <= pb_nxt;
            cnt_q    <= '0;
`ifdef MODEXP_CONST_TIME_EN
            iter_q   <= iter_q + CNT_W'(1);
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid;
  assign bus.busy_o      = busy;
  assign bus.res_o       = res_q;
  assign bus.err_o       = err_q;
endmodule

// File: doc/modexp_param_core.md
Name: modexp_param_core

Overview:
- Parametrised modular exponentiation engine computing res = msg^exp mod mod for WIDTH-bit operands.
- Next-generation core behind the RSA AXI4-lite wrapper; generalises the fixed 32-bit datapath to any WIDTH.
- Uses right-to-left square-and-multiply with two parallel bit-serial interleaved modular multipliers.
- Adds valid/ready handshakes, error reporting for a zero modulus, and a compile-time constant-time mode.

Parameters:
- WIDTH, 64, operand/result width in bits (>= 8).
- CNT_W, $clog2(WIDTH+1), width of internal bit counters; derived, not to be overridden.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  asynchronous active-high reset
- in_valid_i  input  1  operand set valid
- in_ready_o  output  1  core can accept operands
- msg_i  input  WIDTH  message/base
- exp_i  input  WIDTH  exponent
- mod_i  input  WIDTH  modulus
- out_valid_o  output  1  result valid
- out_ready_i  input  1  consumer accepts result
- res_o  output  WIDTH  result
- err_o  output  1  qualifies res_o: mod_i was zero
- busy_o  output  1  state != IDLE

Behaviour:
- Interface: one clock (clk_i); reset rst_i is asynchronous and active-high.
- Reset: state=IDLE; in_ready_o=1; out_valid_o=0; res_o=0; err_o=0; busy_o=0; all datapath registers cleared.
- Reset mid-operation aborts immediately; no result is produced.
- States are IDLE, REDUCE, EXP and DONE. in_ready_o = (state==IDLE).
- Accept occurs on the edge t0 where in_valid_i & in_ready_o. Operands are registered at t0; later input changes are ignored.
- mod_i==0 at accept:
  - go directly to DONE.
  - at edge t0+1: out_valid_o=1, res_o=0, err_o=1.
- one = (mod==1) ? 0 : 1, so that b < M always holds.
- Modular multiply step (one cycle per a-bit, MSB first; P starts 0, all internals WIDTH+1 bits):
  - T = 2P; if T >= M then T -= M.
  - if a[i] then T += b; if T >= M then T -= M.
  - P = T.
  - Invariant: P < M.
- REDUCE (WIDTH cycles): base = msg*one mod M; result = one.
- N = index of highest set bit of exp, plus 1 (N=0 when exp==0).
- After REDUCE: if N==0 go to DONE, otherwise go to EXP.
- EXP: N iterations, each WIDTH cycles, processing exp bits LSB first.
  - Multiplier A computes result*base mod M; it is performed only if the current exp bit is 1, otherwise result is held.
  - Multiplier B computes base*base mod M.
  - Both use the pre-iteration base. Results are committed at the end of the iteration.
- Latency: out_valid_o rises at edge t0 + WIDTH*(1+N); err_o=0.
- DONE:
  - res_o and err_o are held stable while out_valid_o=1.
  - On out_valid_o & out_ready_i: out_valid_o=0 and go to IDLE; in_ready_o=1 on the next cycle.
  - A new accept is not possible in the same cycle as the result handshake.
- mod==1: res_o=0 for any msg/exp.
- exp==0 with mod>1: res_o=1.
- msg >= mod is legal; it is reduced in REDUCE.

Optional Feature:
- Macro: MODEXP_CONST_TIME_EN.
- Defined:
  - N is forced to WIDTH regardless of exp.
  - Multiplier A always runs. On exp bit 0 its output is discarded through a register-select mux, not by gating the multiplier.
  - Latency is exactly WIDTH*(1+WIDTH) cycles for every nonzero modulus.
- Not defined: early termination with N as above.
- The mod==0 error path (1 cycle) is identical in both builds.

Test Plan:
- WIDTH=32, msg=4, exp=13, mod=497, out_ready_i=1 -> res_o=0x1BD, err_o=0, out_valid_o at t0+160 (t0+1056 with MODEXP_CONST_TIME_EN).
- WIDTH=32, msg=0x01234567, exp=0x89ABCDEF, mod=0x11111111 -> res_o=0x0D9EF081 at t0+1056 in both builds.
- WIDTH=32, vectors {1,2,3}->1, {2,2,5}->4, {2,2,3}->1, {0x30000000,0xC0000000,0x00A00001}->0x0000CC3F, issued back-to-back -> each result correct; in_ready_o=0 while busy.
- Boundaries:
  - mod=0 -> res_o=0, err_o=1 at t0+1.
  - mod=1, msg=7, exp=5 -> res_o=0.
  - exp=0, mod=5 -> res_o=1 at t0+32.
- Backpressure: hold out_ready_i=0 for 20 cycles after out_valid_o -> res_o stable, in_ready_o=0; release -> IDLE next cycle.
- Reset mid-EXP, asserted at t0+80 -> outputs at reset values immediately. A subsequent 4^13 mod 497 -> 0x1BD.
